uart_mem_bridge: RTL and testbench
==================================

# uart_mem_bridge

Command-driven byte-stream bridge between the UART receive/transmit byte handshakes and the shared instruction/data RAM port. It is the parametrised successor of the fixed-width UART loader. It adds:
- parametrised data and address widths;
- block read and write with explicit length;
- explicit CPU run/halt control;
- unsolicited fault reporting;
- an inter-byte timeout.

It sits between `uart_rx`/`uart_tx` and `ram` in the board top level, and drives the CPU reset.

## Interface
- `XLEN`, 32: RAM word width in bits; a multiple of 8. `NB = XLEN/8` byte lanes.
- `ADDR_W`, 16: byte-address width; the upper address bits on the wire are ignored.
- `TIMEOUT_CYC`, 1200000: maximum idle cycles between bytes inside a command (100 ms at 12 MHz).
- `clk_i` in 1: system clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `uart_rx_data_i` in 8: received byte.
- `uart_rx_data_vld_i` in 1: received byte valid.
- `uart_rx_data_rdy_o` out 1: bridge accepts the byte; a byte is consumed when vld & rdy.
- `uart_tx_data_o` out 8: byte to transmit.
- `uart_tx_data_vld_o` out 1: transmit request.
- `uart_tx_data_rdy_i` in 1: transmitter accepts; a byte is transferred when vld & rdy.
- `cpu_fault_i` in 1: CPU fault flag, level.
- `cpu_rst_n_o` out 1: CPU reset, active-low; 0 = halted.
- `ram_rw_sel_o` out 1: 1 = bridge owns the RAM port (equals `~cpu_rst_n_o`).
- `ram_rw_addr_o` out ADDR_W: byte address; the RAM uses `[ADDR_W-1:log2(NB)]`.
- `ram_wr_data_o` out XLEN: write byte replicated on all lanes.
- `ram_wr_byte_en_o` out NB: one-hot lane enable, 0 when not writing.
- `ram_rd_data_i` in XLEN: read word, valid one cycle after the address.
- `busy_o` out 1: 1 in every state other than IDLE.

## Operation
Wire format: opcode byte, then fields. Multi-byte fields are little-endian.
- `0x01` WRITE: addr (4 B), len (2 B), then `len` data bytes. Responds `0xA5` after the last byte is written.
- `0x02` READ: addr (4 B), len (2 B). Responds with `len` data bytes, then `0xA5`.
- `0x03` RUN: sets `cpu_rst_n_o` = 1. Responds `0xA5`.
- `0x04` HALT: sets `cpu_rst_n_o` = 0. Responds `0xA5`.
- Unknown opcode: responds `0xEE`, returns to IDLE.
- WRITE or READ while the CPU is running: responds `0xEB` (busy) immediately after the opcode. The remaining bytes are parsed as new opcodes; the host must not send them.
- `len` = 0: no data phase, `0xA5` only.
- Address increments by 1 per byte and wraps modulo `2^ADDR_W`.
- States:
  - IDLE → ADDR (4 B) → LEN (2 B) → WDATA or RD_REQ.
  - RD_REQ → RD_WAIT → RD_SEND → back to RD_REQ, or to RESP.
  - RESP → IDLE.
- `uart_rx_data_rdy_o` = 1 only in IDLE, ADDR, LEN and WDATA, and never while RESP is pending.
- Fault: if `cpu_rst_n_o` = 1 and `cpu_fault_i` = 1 in IDLE:
  - force `cpu_rst_n_o` = 0;
  - send `0xFF` unsolicited.
  - A fault arriving mid-command is handled on return to IDLE. The level stays latched until reported.
- Timeout: if the counter reaches `TIMEOUT_CYC` in ADDR, LEN or WDATA without a consumed byte:
  - abort and send `0xEE`;
  - bytes already written stay written.
  - The counter clears on every consumed byte and in IDLE.

## Timing
- Reset values:
  - `cpu_rst_n_o` = 0, `ram_rw_sel_o` = 1;
  - all other outputs 0; state IDLE.
- Write: `ram_wr_byte_en_o[addr % NB]` pulses 1 for exactly the cycle after the data byte is consumed, with the address and data registered.
- Read: address driven in RD_REQ. Lane `addr % NB` of `ram_rd_data_i` is captured in RD_WAIT, one cycle later. `uart_tx_data_vld_o` rises the next cycle.
- Tx handshake: `uart_tx_data_o` is stable while `uart_tx_data_vld_o` = 1. Vld drops the cycle after vld & rdy.
- RUN/HALT take effect on the `cpu_rst_n_o` edge in the cycle after the opcode is consumed, before `0xA5` is sent.
- `rst_i` asserted mid-command: immediate return to reset values; no response is sent.

## Structure
- Package `uart_mem_bridge_pkg`:
  - opcode constants (`OP_WRITE`, `OP_READ`, `OP_RUN`, `OP_HALT`);
  - response constants (`RSP_ACK = 8'hA5`, `RSP_NAK = 8'hEE`, `RSP_BUSY = 8'hEB`, `RSP_FAULT = 8'hFF`);
  - the state enum `bridge_state_t`.
- Sub-module `bridge_wdt`: an inter-byte timeout counter with `clr`/`en`/`expired` ports.

## Test plan
- HALT, then WRITE addr `0x10`, len 5, data `11 22 33 44 55` → byte enables `0001,0010,0100,1000,0001`; RAM words `0x10` = `44332211`, `0x14` = `xxxxxx55`; response `A5`.
- READ addr `0x11`, len 3 after the previous test → tx `22 33 44 A5`; every byte held stable while `uart_tx_data_rdy_i` is stalled for 20 cycles.
- RUN → `cpu_rst_n_o` 0→1, `ram_rw_sel_o` 1→0, `A5`. Then WRITE → `EB`; then assert `cpu_fault_i` → `cpu_rst_n_o` = 0, tx `FF`.
- WRITE addr `0xFFFF`, len 2, `ADDR_W` = 16 → writes at `0xFFFF` then `0x0000`; response `A5`.
- WRITE header, then stop after 2 data bytes (TIMEOUT_CYC = 100 in sim) → `EE` at cycle 100 after the last byte; returns to IDLE; next opcode `0x99` → `EE`.
- `rst_i` pulse in the middle of a READ data phase → all outputs at reset values asynchronously; no further tx.

Source files
------------

// File: rtl/uart_mem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_mem_bridge_pkg
// Shared constants and types for the UART-to-memory command bridge:
//   - wire-protocol opcodes and response codes
//   - field lengths of the command header
//   - the bridge FSM state type
// -----------------------------------------------------------------------------
package uart_mem_bridge_pkg;

    // Command opcodes (first byte of every command)
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_RUN   = 8'h03;
    localparam logic [7:0] OP_HALT  = 8'h04;

    // Response codes sent back to the host
    localparam logic [7:0] RSP_ACK   = 8'hA5;
    localparam logic [7:0] RSP_NAK   = 8'hEE;
    localparam logic [7:0] RSP_BUSY  = 8'hEB;
    localparam logic [7:0] RSP_FAULT = 8'hFF;

    // Header field sizes on the wire (little-endian)
    localparam int ADDR_BYTES = 4;
    localparam int LEN_BYTES  = 2;

    // ST_WSTROBE is the single cycle in which the registered write is
    // presented to the RAM; ST_RESP holds any response byte until taken.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WSTROBE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_RESP
    } bridge_state_t;

endpackage

// File: rtl/uart_mem_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_mem_bridge_if
// Bundles every non-clock/reset signal of the bridge.
//   master : the bridge side (drives rx ready, tx byte, RAM port, CPU reset)
//   slave  : the board side (UART rx/tx, RAM, CPU fault)
// Signals:
//   uart_rx_data_i / _vld_i / _rdy_o : received byte handshake
//   uart_tx_data_o / _vld_o / _rdy_i : transmit byte handshake
//   cpu_fault_i, cpu_rst_n_o         : CPU fault level / active-low CPU reset
//   ram_rw_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
//   ram_rd_data_i                    : shared RAM port
//   busy_o                           : bridge is not idle
// -----------------------------------------------------------------------------
interface uart_mem_bridge_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 16
);
    localparam int NB = XLEN / 8;

    logic [7:0]        uart_rx_data_i;
    logic              uart_rx_data_vld_i;
    logic              uart_rx_data_rdy_o;
    logic [7:0]        uart_tx_data_o;
    logic              uart_tx_data_vld_o;
    logic              uart_tx_data_rdy_i;
    logic              cpu_fault_i;
    logic              cpu_rst_n_o;
    logic              ram_rw_sel_o;
    logic [ADDR_W-1:0] ram_rw_addr_o;
    logic [XLEN-1:0]   ram_wr_data_o;
    logic [NB-1:0]     ram_wr_byte_en_o;
    logic [XLEN-1:0]   ram_rd_data_i;
    logic              busy_o;

    modport master (
        input  uart_rx_data_i, uart_rx_data_vld_i,
        output uart_rx_data_rdy_o,
        output uart_tx_data_o, uart_tx_data_vld_o,
        input  uart_tx_data_rdy_i,
        input  cpu_fault_i,
        output cpu_rst_n_o,
        output ram_rw_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
        input  ram_rd_data_i,
        output busy_o
    );

    modport slave (
        output uart_rx_data_i, uart_rx_data_vld_i,
        input  uart_rx_data_rdy_o,
        input  uart_tx_data_o, uart_tx_data_vld_o,
        output uart_tx_data_rdy_i,
        output cpu_fault_i,
        input  cpu_rst_n_o,
        input  ram_rw_sel_o, ram_rw_addr_o, ram_wr_data_o, ram_wr_byte_en_o,
        output ram_rd_data_i,
        input  busy_o
    );

endinterface

// File: rtl/bridge_wdt.sv
// -----------------------------------------------------------------------------
// bridge_wdt
// Inter-byte timeout counter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr          : restart the count (byte consumed, or bridge idle)
//   en           : count this cycle
//   expired      : count has reached TIMEOUT_CYC; held until clr
// -----------------------------------------------------------------------------
module bridge_wdt #(
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int                CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at LIMIT so expired stays up until the bridge clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/uart_mem_bridge.sv
// -----------------------------------------------------------------------------
// uart_mem_bridge
// Command-driven bridge between the UART byte handshakes and the shared RAM
// port; also owns the CPU run/halt reset and reports CPU faults.
//   clk_i : system clock
//   rst_i : asynchronous active-high reset
//   bus   : uart_mem_bridge_if.master (UART rx/tx, RAM port, CPU control)
// Parameters:
//   XLEN        : RAM word width (multiple of 8, at least 16)
//   ADDR_W      : byte address width (at most 32)
//   TIMEOUT_CYC : idle cycles allowed between bytes of one command
// -----------------------------------------------------------------------------
module uart_mem_bridge
    import uart_mem_bridge_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_mem_bridge_if.master  bus
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);

    bridge_state_t      state_q, state_d;

    logic               cpu_run_q, run_d;
    logic               fault_q, fault_now;
    logic [ADDR_W-1:0]  addr_q, addr_field;
    logic [15:0]        len_q, len_field;
    logic [1:0]         field_cnt_q;
    logic               op_write_q;
    logic [7:0]         wdata_q, tx_q, rsp_d, rd_byte;
    logic               rsp_load;
    logic               rx_rdy, rx_fire, tx_vld, tx_fire;
    logic               wdt_clr, wdt_en, wdt_expired;
    logic [LB-1:0]      lane;
    logic [NB-1:0]      wr_be;

    assign rx_fire   = rx_rdy & bus.uart_rx_data_vld_i;
    assign tx_fire   = tx_vld & bus.uart_tx_data_rdy_i;
    assign fault_now = cpu_run_q & (fault_q | bus.cpu_fault_i);
    assign lane      = addr_q[LB-1:0];
    assign rd_byte   = bus.ram_rd_data_i[{lane, 3'b000} +: 8];
    assign len_field = {bus.uart_rx_data_i, len_q[15:8]};

    // Drop the incoming address byte into its little-endian position;
    // wire bits beyond ADDR_W are simply ignored.
    always_comb begin
        addr_field = addr_q;
        for (int i = 0; i < ADDR_W; i++) begin
            if (i < 8 * ADDR_BYTES && field_cnt_q == 2'(i / 8)) begin
                addr_field[i] = bus.uart_rx_data_i[i % 8];
            end
        end
    end

    bridge_wdt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (wdt_clr),
        .en      (wdt_en),
        .expired (wdt_expired)
    );

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, plus the response byte and CPU run level decided on the
    // same transitions.
    always_comb begin
        state_d  = state_q;
        run_d    = cpu_run_q;
        rsp_load = 1'b0;
        rsp_d    = RSP_ACK;
        case (state_q)
            ST_IDLE: begin
                if (fault_now) begin
                    run_d    = 1'b0;
                    rsp_load = 1'b1;
                    rsp_d    = RSP_FAULT;
                    state_d  = ST_RESP;
                end else if (rx_fire) begin
                    rsp_load = 1'b1;
                    state_d  = ST_RESP;
                    case (bus.uart_rx_data_i)
                        OP_WRITE, OP_READ: begin
                            if (cpu_run_q) begin
                                rsp_d = RSP_BUSY;
                            end else begin
                                rsp_load = 1'b0;
                                state_d  = ST_ADDR;
                            end
                        end
                        OP_RUN:  run_d = 1'b1;
                        OP_HALT: run_d = 1'b0;
                        default: rsp_d = RSP_NAK;
                    endcase
                end
            end
            ST_ADDR: begin
                if (wdt_expired) begin
                    rsp_load = 1'b1;
                    rsp_d    = RSP_NAK;
                    state_d  = ST_RESP;
                end else if (rx_fire && field_cnt_q == 2'(ADDR_BYTES - 1)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (wdt_expired) begin
                    rsp_load = 1'b1;
                    rsp_d    = RSP_NAK;
                    state_d  = ST_RESP;
                end else if (rx_fire && field_cnt_q == 2'(LEN_BYTES - 1)) begin
                    if (len_field == 16'd0) begin
                        rsp_load = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = op_write_q ? ST_WDATA : ST_RD_REQ;
                    end
                end
            end
            ST_WDATA: begin
                if (wdt_expired) begin
                    rsp_load = 1'b1;
                    rsp_d    = RSP_NAK;
                    state_d  = ST_RESP;
                end else if (rx_fire) begin
                    state_d = ST_WSTROBE;
                end
            end
            ST_WSTROBE: begin
                if (len_q == 16'd1) begin
                    rsp_load = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_WDATA;
                end
            end
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_RD_SEND;
            ST_RD_SEND: begin
                if (tx_fire) begin
                    if (len_q == 16'd1) begin
                        rsp_load = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RESP: begin
                if (tx_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake, write strobe and watchdog controls. Rx ready is withheld
    // while a fault report is about to go out, once the timeout has fired,
    // and while reset is held so every output reads 0 in reset.
    always_comb begin
        rx_rdy = 1'b0;
        tx_vld = 1'b0;
        wdt_en = 1'b0;
        wr_be  = '0;
        case (state_q)
            ST_IDLE: rx_rdy = ~fault_now;
            ST_ADDR, ST_LEN, ST_WDATA: begin
                rx_rdy = ~wdt_expired;
                wdt_en = 1'b1;
            end
            ST_WSTROBE: wr_be = NB'(1) << lane;
            ST_RD_SEND, ST_RESP: tx_vld = 1'b1;
            default: ;
        endcase
        if (rst_i) begin
            rx_rdy = 1'b0;
        end
    end

    assign wdt_clr = (state_q == ST_IDLE) | rx_fire;

    // Datapath: header fields, RAM address/data, tx byte, CPU run level.
    // The fault level is only remembered while the CPU is running, so a
    // halted CPU never produces a stale report.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cpu_run_q   <= 1'b0;
            fault_q     <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            field_cnt_q <= '0;
            op_write_q  <= 1'b0;
            wdata_q     <= '0;
            tx_q        <= '0;
        end else begin
            cpu_run_q <= run_d;
            fault_q   <= cpu_run_q & (fault_q | bus.cpu_fault_i);
            if (rsp_load) begin
                tx_q <= rsp_d;
            end
            case (state_q)
                ST_IDLE: begin
                    field_cnt_q <= '0;
                    if (rx_fire) begin
                        op_write_q <= (bus.uart_rx_data_i == OP_WRITE);
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_q      <= addr_field;
                        field_cnt_q <= field_cnt_q + 2'd1;
                    end
                end
                ST_LEN: begin
                    if (rx_fire) begin
                        len_q       <= len_field;
                        field_cnt_q <= field_cnt_q + 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (rx_fire) begin
                        wdata_q <= bus.uart_rx_data_i;
                    end
                end
                ST_WSTROBE: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    len_q  <= len_q - 16'd1;
                end
                ST_RD_WAIT: tx_q <= rd_byte;
                ST_RD_SEND: begin
                    if (tx_fire) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        len_q  <= len_q - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.uart_rx_data_rdy_o = rx_rdy;
    assign bus.uart_tx_data_o     = tx_q;
    assign bus.uart_tx_data_vld_o = tx_vld;
    assign bus.cpu_rst_n_o        = cpu_run_q;
    assign bus.ram_rw_sel_o       = ~cpu_run_q;
    assign bus.ram_rw_addr_o      = addr_q;
    assign bus.ram_wr_data_o      = {NB{wdata_q}};
    assign bus.ram_wr_byte_en_o   = wr_be;
    assign bus.busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_mem_bridge
// Directed bench for uart_mem_bridge with a small byte-lane RAM model.
// -----------------------------------------------------------------------------
module tb_uart_mem_bridge;
    import uart_mem_bridge_pkg::*;

    localparam int XLEN    = 32;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_mem_bridge_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

    uart_mem_bridge #(
        .XLEN        (XLEN),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // RAM model: registered read, byte-lane write while the bridge owns it
    logic [31:0] ram [0:16383];
    logic [31:0] rd_q;

    always @(posedge clk) begin
        if (bus.ram_rw_sel_o) begin
            for (int l = 0; l < 4; l++) begin
                if (bus.ram_wr_byte_en_o[l]) begin
                    ram[bus.ram_rw_addr_o[15:2]][l*8 +: 8] <= bus.ram_wr_data_o[l*8 +: 8];
                end
            end
        end
        rd_q <= ram[bus.ram_rw_addr_o[15:2]];
    end

    assign bus.ram_rd_data_i = rd_q;

    // Record every write strobe with its address
    logic [15:0] be_addr_q [$];
    logic [3:0]  be_val_q  [$];

    always @(negedge clk) begin
        if (bus.ram_wr_byte_en_o != 4'd0) begin
            be_addr_q.push_back(bus.ram_rw_addr_o);
            be_val_q.push_back(bus.ram_wr_byte_en_o);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte on the rx handshake and hold it until it is consumed
    task automatic apply_stimulus(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.uart_rx_data_i     = b;
        bus.uart_rx_data_vld_i = 1'b1;
        while (!bus.uart_rx_data_rdy_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("rx_accept_%02h", b), 32'(bus.uart_rx_data_rdy_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.uart_rx_data_vld_i = 1'b0;
    endtask

    // Wait for a tx byte, stall it, check value/stability, then take it
    task automatic expect_tx(input string tag, input logic [7:0] exp, input int stall, input bit chk_drop);
        int   n      = 0;
        logic stable = 1'b1;
        logic [7:0] first;
        @(negedge clk);
        while (!bus.uart_tx_data_vld_o && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, "_vld"}, 32'(bus.uart_tx_data_vld_o), 32'd1);
        first = bus.uart_tx_data_o;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!bus.uart_tx_data_vld_o || bus.uart_tx_data_o !== first) stable = 1'b0;
        end
        if (stall > 0) check_output({tag, "_stable"}, 32'(stable), 32'd1);
        check_output(tag, 32'(bus.uart_tx_data_o), 32'(exp));
        bus.uart_tx_data_rdy_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.uart_tx_data_rdy_i = 1'b0;
        if (chk_drop) check_output({tag, "_vld_drop"}, 32'(bus.uart_tx_data_vld_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_cpu_rst_n"}, 32'(bus.cpu_rst_n_o), 32'd0);
        check_output({tag, "_ram_sel"},   32'(bus.ram_rw_sel_o), 32'd1);
        check_output({tag, "_rx_rdy"},    32'(bus.uart_rx_data_rdy_o), 32'd0);
        check_output({tag, "_tx_vld"},    32'(bus.uart_tx_data_vld_o), 32'd0);
        check_output({tag, "_tx_data"},   32'(bus.uart_tx_data_o), 32'd0);
        check_output({tag, "_addr"},      32'(bus.ram_rw_addr_o), 32'd0);
        check_output({tag, "_wdata"},     bus.ram_wr_data_o, 32'd0);
        check_output({tag, "_be"},        32'(bus.ram_wr_byte_en_o), 32'd0);
        check_output({tag, "_busy"},      32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        logic [7:0] seq [$];
        logic [3:0]  exp_be   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [15:0] exp_addr [5] = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0014};
        int   n;
        logic seen;

        bus.uart_rx_data_i     = 8'h00;
        bus.uart_rx_data_vld_i = 1'b0;
        bus.uart_tx_data_rdy_i = 1'b0;
        bus.cpu_fault_i        = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_rx_rdy", 32'(bus.uart_rx_data_rdy_o), 32'd1);

        // HALT
        $display("[TB] HALT");
        apply_stimulus(OP_HALT);
        expect_tx("halt_ack", RSP_ACK, 0, 1'b1);
        check_output("halt_cpu_rst_n", 32'(bus.cpu_rst_n_o), 32'd0);

        // WRITE 0x10, len 5
        $display("[TB] WRITE 0x10 len 5");
        be_addr_q.delete();
        be_val_q.delete();
        seq = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (seq[i]) apply_stimulus(seq[i]);
        expect_tx("wr_ack", RSP_ACK, 0, 1'b1);
        check_output("wr_be_count", 32'(be_val_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("wr_be_%0d", i), 32'(be_val_q[i]), 32'(exp_be[i]));
            check_output($sformatf("wr_addr_%0d", i), 32'(be_addr_q[i]), 32'(exp_addr[i]));
        end
        check_output("ram_word_10", ram[4], 32'h44332211);
        check_output("ram_word_14_lane0", 32'(ram[5][7:0]), 32'h55);

        // READ 0x11, len 3 with stalled transmitter
        $display("[TB] READ 0x11 len 3");
        seq = '{8'h02, 8'h11, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
        foreach (seq[i]) apply_stimulus(seq[i]);
        expect_tx("rd_byte0", 8'h22, 20, 1'b1);
        expect_tx("rd_byte1", 8'h33, 20, 1'b1);
        expect_tx("rd_byte2", 8'h44, 20, 1'b0);
        expect_tx("rd_ack", RSP_ACK, 0, 1'b1);

        // WRITE across the address wrap
        $display("[TB] WRITE 0xFFFF len 2");
        be_addr_q.delete();
        be_val_q.delete();
        seq = '{8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB};
        foreach (seq[i]) apply_stimulus(seq[i]);
        expect_tx("wrap_ack", RSP_ACK, 0, 1'b1);
        check_output("wrap_be_count", 32'(be_val_q.size()), 32'd2);
        check_output("wrap_addr0", 32'(be_addr_q[0]), 32'h0000FFFF);
        check_output("wrap_be0", 32'(be_val_q[0]), 32'b1000);
        check_output("wrap_addr1", 32'(be_addr_q[1]), 32'h00000000);
        check_output("wrap_be1", 32'(be_val_q[1]), 32'b0001);
        check_output("wrap_ram_top", 32'(ram[16383][31:24]), 32'hAA);
        check_output("wrap_ram_zero", 32'(ram[0][7:0]), 32'hBB);

        // Inter-byte timeout after two of four data bytes
        $display("[TB] timeout");
        seq = '{8'h01, 8'h20, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h01, 8'h02};
        foreach (seq[i]) apply_stimulus(seq[i]);
        n = 0;
        while (!bus.uart_tx_data_vld_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output("timeout_latency_ok", 32'(n >= TIMEOUT && n <= TIMEOUT + 4), 32'd1);
        expect_tx("timeout_nak", RSP_NAK, 0, 1'b1);
        check_output("timeout_idle", 32'(bus.busy_o), 32'd0);
        check_output("timeout_kept_bytes", 32'(ram[8][15:0]), 32'h0201);
        apply_stimulus(8'h99);
        expect_tx("unknown_nak", RSP_NAK, 0, 1'b1);

        // RUN, busy rejection, fault report
        $display("[TB] RUN / busy / fault");
        check_output("pre_run_cpu_rst_n", 32'(bus.cpu_rst_n_o), 32'd0);
        apply_stimulus(OP_RUN);
        check_output("run_cpu_rst_n", 32'(bus.cpu_rst_n_o), 32'd1);
        check_output("run_ram_sel", 32'(bus.ram_rw_sel_o), 32'd0);
        expect_tx("run_ack", RSP_ACK, 0, 1'b1);
        apply_stimulus(OP_WRITE);
        expect_tx("busy_rsp", RSP_BUSY, 0, 1'b1);
        bus.cpu_fault_i = 1'b1;
        expect_tx("fault_rsp", RSP_FAULT, 0, 1'b1);
        check_output("fault_cpu_rst_n", 32'(bus.cpu_rst_n_o), 32'd0);
        check_output("fault_ram_sel", 32'(bus.ram_rw_sel_o), 32'd1);
        bus.cpu_fault_i = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.uart_tx_data_vld_o) seen = 1'b1;
        end
        check_output("fault_single_report", 32'(seen), 32'd0);

        // Reset in the middle of a READ data phase
        $display("[TB] reset mid READ");
        seq = '{8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00};
        foreach (seq[i]) apply_stimulus(seq[i]);
        n = 0;
        while (!bus.uart_tx_data_vld_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_output("midrd_first_vld", 32'(bus.uart_tx_data_vld_o), 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("midrd");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.uart_tx_data_rdy_i = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.uart_tx_data_vld_o) seen = 1'b1;
        end
        bus.uart_tx_data_rdy_i = 1'b0;
        check_output("midrd_no_tx", 32'(seen), 32'd0);
        check_output("midrd_idle_rdy", 32'(bus.uart_rx_data_rdy_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
